sound_mixer_dac: RTL

//  Final audio stage. Consumes the four 8-bit DAC latches from the covox/specdrum/soundrive

---
 rtl/sound_mixer_dac.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/sound_mixer_dac.sv
// -----------------------------------------------------------------------------
// sound_mixer_dac
//
// Final audio stage. An 8-step sequencer takes a snapshot of all sound sources:
// the covox/soundrive DAC latches, the AY channel levels, the beeper and
// tape_out. Over the next steps it sums them into two 12-bit accumulators, then
// latches saturated 11-bit left/right samples. One sample is produced every
// 8 clk28 cycles, which is 3.5 MHz. Each side then feeds a first-order
// sigma-delta modulator. The 1-bit outputs drive the RC-filtered audio pins.
// The output carries DC (0x80 on the channels is silence), and the board
// AC-couples it.
//
// Parameters
//   BEEPER_LEVEL  level added to both sides while beeper=1
//   TAPE_LEVEL    level added to both sides while tape_out=1
//
// Ports
//   clk28        in   1   system clock, 28 MHz
//   rst_n        in   1   asynchronous active-low reset
//   mute         in   1   forces the next latched samples to 0
//   ay_abc       in   1   1: ABC stereo panning of the AY, 0: mono AY
//   ch_l0/ch_l1  in   8   left covox/soundrive channels, unsigned
//   ch_r0/ch_r1  in   8   right covox/soundrive channels, unsigned
//   ay_a/b/c     in   8   AY channel amplitudes, unsigned
//   beeper       in   1   ULA beeper bit
//   tape_out     in   1   ULA tape output bit
//   mix_l/mix_r  out  11  latched mixed samples
//   sample_stb   out  1   one-cycle pulse when mix_l/mix_r update
//   dac_l/dac_r  out  1   sigma-delta bitstreams
// -----------------------------------------------------------------------------
module sound_mixer_dac #(
    parameter logic [10:0] BEEPER_LEVEL = 11'd128,
    parameter logic [10:0] TAPE_LEVEL   = 11'd32
) (
    input  logic        clk28,
    input  logic        rst_n,
    input  logic        mute,
    input  logic        ay_abc,
    input  logic [7:0]  ch_l0,
    input  logic [7:0]  ch_l1,
    input  logic [7:0]  ch_r0,
    input  logic [7:0]  ch_r1,
    input  logic [7:0]  ay_a,
    input  logic [7:0]  ay_b,
    input  logic [7:0]  ay_c,
    input  logic        beeper,
    input  logic        tape_out,
    output logic [10:0] mix_l,
    output logic [10:0] mix_r,
    output logic        sample_stb,
    output logic        dac_l,
    output logic        dac_r
);

    typedef enum logic [2:0] {
        S_SNAP  = 3'd0,  // capture all inputs into shadow registers
        S_LOAD  = 3'd1,  // acc = channel 0
        S_ADD1  = 3'd2,  // acc += channel 1
        S_AY    = 3'd3,  // acc += AY contribution
        S_BEEP  = 3'd4,  // acc += beeper / tape levels
        S_LATCH = 3'd5,  // saturate and latch mix outputs
        S_IDLE6 = 3'd6,
        S_IDLE7 = 3'd7
    } step_t;

    step_t       step;

    // Shadow copies of the inputs. Every step of one sample works from a single
    // coherent snapshot.
    logic [7:0]  sh_l0, sh_l1, sh_r0, sh_r1;
    logic [7:0]  sh_a, sh_b, sh_c;
    logic        sh_beep, sh_tape, sh_abc;

    logic [11:0] acc_l, acc_r;
    logic [11:0] sd_l, sd_r;

    // AY and level contributions, derived from the shadow registers.
    logic [9:0]  ay_sum;
    logic [11:0] ay_add_l, ay_add_r;
    logic [11:0] lvl_add;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        ay_add_l = 12'd0;
        ay_add_r = 12'd0;
        // The three-channel sum needs 10 bits (max 765) before halving.
        ay_sum   = {2'b00, sh_a} + {2'b00, sh_b} + {2'b00, sh_c};
        if (sh_abc) begin
            // Stereo: A left, C right, B split as half level to both sides.
            ay_add_l = {4'd0, sh_a} + {5'd0, sh_b[7:1]};
            ay_add_r = {4'd0, sh_c} + {5'd0, sh_b[7:1]};
        end else begin
            ay_add_l = {3'd0, ay_sum[9:1]};
            ay_add_r = {3'd0, ay_sum[9:1]};
        end
        lvl_add = (sh_beep ? {1'b0, BEEPER_LEVEL} : 12'd0)
                + (sh_tape ? {1'b0, TAPE_LEVEL}   : 12'd0);
    end

    // Sequencer with registered outputs.
    // NOTE: sequential state uses non-blocking assignments only. Then every
    // register samples its pre-edge values, whatever the statement order.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these are a handful of flops, not a memory array. All of
            // them are reset, so an interrupted sequence never leaks a
            // partial sample.
            step       <= S_SNAP;
            sh_l0      <= '0;
            sh_l1      <= '0;
            sh_r0      <= '0;
            sh_r1      <= '0;
            sh_a       <= '0;
            sh_b       <= '0;
            sh_c       <= '0;
            sh_beep    <= 1'b0;
            sh_tape    <= 1'b0;
            sh_abc     <= 1'b0;
            acc_l      <= '0;
            acc_r      <= '0;
            mix_l      <= '0;
            mix_r      <= '0;
            sample_stb <= 1'b0;
        end else begin
            step       <= step_t'(step + 3'd1);
            sample_stb <= (step == S_LATCH);
            case (step)
                S_SNAP: begin
                    sh_l0   <= ch_l0;
                    sh_l1   <= ch_l1;
                    sh_r0   <= ch_r0;
                    sh_r1   <= ch_r1;
                    sh_a    <= ay_a;
                    sh_b    <= ay_b;
                    sh_c    <= ay_c;
                    sh_beep <= beeper;
                    sh_tape <= tape_out;
                    sh_abc  <= ay_abc;
                end
                S_LOAD: begin
                    acc_l <= {4'd0, sh_l0};
                    acc_r <= {4'd0, sh_r0};
                end
                S_ADD1: begin
                    acc_l <= acc_l + {4'd0, sh_l1};
                    acc_r <= acc_r + {4'd0, sh_r1};
                end
                S_AY: begin
                    acc_l <= acc_l + ay_add_l;
                    acc_r <= acc_r + ay_add_r;
                end
                S_BEEP: begin
                    acc_l <= acc_l + lvl_add;
                    acc_r <= acc_r + lvl_add;
                end
                S_LATCH: begin
                    // mute is looked at only here. It takes effect, or is
                    // released, on a whole-sample boundary.
                    if (mute) begin
                        mix_l <= '0;
                        mix_r <= '0;
                    end else begin
                        mix_l <= acc_l[11] ? 11'h7FF : acc_l[10:0];
                        mix_r <= acc_r[11] ? 11'h7FF : acc_r[10:0];
                    end
                end
                default: ;  // idle steps 6 and 7
            endcase
        end
    end

    // First-order sigma-delta. The carry out of the 11-bit accumulator is the
    // bitstream, so the density of ones is mix/2048. It runs every clk28,
    // independent of the sequencer step.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            sd_l  <= '0;
            sd_r  <= '0;
            dac_l <= 1'b0;
            dac_r <= 1'b0;
        end else begin
            sd_l  <= {1'b0, sd_l[10:0]} + {1'b0, mix_l};
            sd_r  <= {1'b0, sd_r[10:0]} + {1'b0, mix_r};
            dac_l <= sd_l[11];
            dac_r <= sd_r[11];
        end
    end

endmodule
